// File: rtl/dac_output_stage_if.sv
// Signal bundle between the filter chain, the dac_output_stage and the dac driver.
interface dac_output_stage_if #(
  parameter int NCH   = 2,
  parameter int NSRC  = 4,
  parameter int IN_W  = 16,
  parameter int DAC_W = 14,
  parameter int SEL_W = $clog2(NSRC)
);
  logic [NSRC*IN_W-1:0] src_data;
  logic [NSRC-1:0]      src_valid;
  logic [NCH*SEL_W-1:0] sel_req;
  logic [NCH*4-1:0]     shift;
  logic                 sat_clr;
  logic [NCH*DAC_W-1:0] dac_data;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       sat;

  modport master (
    output src_data, src_valid, sel_req, shift, sat_clr,
    input  dac_data, busy, sat
  );

  modport slave (
    input  src_data, src_valid, sel_req, shift, sat_clr,
    output dac_data, busy, sat
  );
endinterface

// File: rtl/dac_output_stage.sv
// Multi-channel DAC output stage: per-channel source select with click-free fade,
// programmable arithmetic shift, saturation and offset-binary encoding.
module dac_output_stage #(
  parameter int NCH       = 2,
  parameter int NSRC      = 4,
  parameter int IN_W      = 16,
  parameter int DAC_W     = 14,
  parameter int RAMP_LOG2 = 4,
  parameter int SEL_W     = $clog2(NSRC)
) (
  input logic               sys_clk,
  input logic               reset,
  dac_output_stage_if.slave bus
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = IN_W + GW + 1;
  localparam logic [GW-1:0] GAIN_FULL = GW'(1 << RAMP_LOG2);
  localparam logic signed [IN_W-1:0] Z_MAX = IN_W'((2 ** (DAC_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] Z_MIN = IN_W'(-(2 ** (DAC_W - 1)));
  localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};

  typedef enum logic [1:0] {RUN, FADE_OUT, SWAP, FADE_IN} state_e;

  logic signed [IN_W-1:0] hold_q [NSRC];

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NSRC; s++) hold_q[s] <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (bus.src_valid[s]) hold_q[s] <= bus.src_data[s*IN_W +: IN_W];
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e                 state_q, state_d;
    logic [GW-1:0]          gain_q, gain_d;
    logic [SEL_W-1:0]       sel_act_q, sel_act_d;
    logic [SEL_W-1:0]       sel_req;
    logic [3:0]             shamt;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_sh;
    logic signed [IN_W-1:0] y_d, y_q;
    logic signed [IN_W-1:0] z;
    logic                   clamp_hi, clamp_lo;
    logic [DAC_W-1:0]       dac_d, dac_q;
    logic                   sat_d, sat_q;

    assign sel_req = bus.sel_req[c*SEL_W +: SEL_W];
    assign shamt   = bus.shift[c*4 +: 4];

    // A reversal during fade-in turns around at the current gain, so the output never steps.
    always_comb begin
      state_d   = state_q;
      gain_d    = gain_q;
      sel_act_d = sel_act_q;
      case (state_q)
        RUN: begin
          gain_d = GAIN_FULL;
          if (sel_req != sel_act_q) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          if (gain_q <= GW'(1)) begin
            gain_d  = '0;
            state_d = SWAP;
          end else begin
            gain_d = gain_q - GW'(1);
          end
        end
        SWAP: begin
          sel_act_d = sel_req;
          state_d   = FADE_IN;
        end
        FADE_IN: begin
          if (sel_req != sel_act_q) begin
            state_d = FADE_OUT;
          end else begin
            gain_d = gain_q + GW'(1);
            if (gain_q + GW'(1) == GAIN_FULL) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    assign prod    = PW'(hold_q[sel_act_q]) * PW'($signed({1'b0, gain_q}));
    assign prod_sh = prod >>> RAMP_LOG2;
    assign y_d     = prod_sh[IN_W-1:0];

    // Second stage: the unity-gain product always fits IN_W, so clamp after the user shift.
    assign z        = y_q >>> shamt;
    assign clamp_hi = (z > Z_MAX);
    assign clamp_lo = (z < Z_MIN);

    always_comb begin
      dac_d = {~z[DAC_W-1], z[DAC_W-2:0]};
      if (clamp_hi) dac_d = '1;
      else if (clamp_lo) dac_d = '0;
    end

    assign sat_d = clamp_hi | clamp_lo | (sat_q & ~bus.sat_clr);

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        state_q   <= RUN;
        gain_q    <= GAIN_FULL;
        sel_act_q <= '0;
        y_q       <= '0;
        dac_q     <= MIDSCALE;
        sat_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        gain_q    <= gain_d;
        sel_act_q <= sel_act_d;
        y_q       <= y_d;
        dac_q     <= dac_d;
        sat_q     <= sat_d;
      end
    end

    assign bus.dac_data[c*DAC_W +: DAC_W] = dac_q;
    assign bus.busy[c]                     = (state_q != RUN);
    assign bus.sat[c]                      = sat_q;
  end

endmodule

// File: tb/tb_dac_output_stage.sv
// Self-checking bench for dac_output_stage: directed scenarios plus random traffic,
// scored against a cycle-level behavioural model through an expectation queue.
module tb_dac_output_stage;

  localparam int NCH   = 2;
  localparam int NSRC  = 4;
  localparam int IN_W  = 16;
  localparam int DAC_W = 14;
  localparam int RLOG  = 4;
  localparam int SEL_W = 2;
  localparam int FULL  = 16;
  localparam int MID   = 8192;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  dac_output_stage_if #(.NCH(NCH), .NSRC(NSRC), .IN_W(IN_W), .DAC_W(DAC_W)) bus ();

  dac_output_stage #(
    .NCH(NCH), .NSRC(NSRC), .IN_W(IN_W), .DAC_W(DAC_W), .RAMP_LOG2(RLOG)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [NCH*DAC_W-1:0] dac;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       sat;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  // Reference model state: gain walks toward full scale unless heading down for a swap.
  int mHold[NSRC];
  int mGain[NCH];
  int mAct[NCH];
  bit mDown[NCH];
  bit mSwapNow[NCH];
  int mY[NCH];
  bit mSat[NCH];

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int toCode(input int y, input int sh, output bit hit);
    int zv;
    zv  = floorDiv(y, 1 << sh);
    hit = 1'b0;
    if (zv > MID - 1) begin
      hit = 1'b1;
      zv  = MID - 1;
    end else if (zv < -MID) begin
      hit = 1'b1;
      zv  = -MID;
    end
    return zv + MID;
  endfunction

  function automatic int dacLane(input int c);
    return int'(bus.dac_data[c*DAC_W +: DAC_W]);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int s = 0; s < NSRC; s++) mHold[s] = 0;
    for (int c = 0; c < NCH; c++) begin
      mGain[c]    = FULL;
      mAct[c]     = 0;
      mDown[c]    = 1'b0;
      mSwapNow[c] = 1'b0;
      mY[c]       = 0;
      mSat[c]     = 1'b0;
    end
    expQ.delete();
  endtask

  task automatic setSel(input int c, input int v);
    bus.sel_req[c*SEL_W +: SEL_W] = SEL_W'(v);
  endtask

  task automatic setShift(input int c, input int v);
    bus.shift[c*4 +: 4] = 4'(v);
  endtask

  task automatic applyStimulus(input int s, input int v);
    bus.src_data[s*IN_W +: IN_W] = IN_W'(v);
    bus.src_valid[s] = 1'b1;
    @(negedge sys_clk);
    bus.src_valid[s] = 1'b0;
  endtask

  // Model: evaluated on every rising edge with the inputs as the DUT samples them.
  initial begin
    exp_t e;
    bit   hit;
    int   req;
    forever begin
      @(posedge sys_clk);
      if (!reset) begin
        e = '0;
        for (int c = 0; c < NCH; c++) begin
          e.dac[c*DAC_W +: DAC_W] = DAC_W'(toCode(mY[c], int'(bus.shift[c*4 +: 4]), hit));
          if (hit) mSat[c] = 1'b1;
          else if (bus.sat_clr) mSat[c] = 1'b0;
          e.sat[c] = mSat[c];
          mY[c] = floorDiv(mHold[mAct[c]] * mGain[c], FULL);
        end
        for (int s = 0; s < NSRC; s++) begin
          if (bus.src_valid[s]) mHold[s] = int'($signed(bus.src_data[s*IN_W +: IN_W]));
        end
        for (int c = 0; c < NCH; c++) begin
          req = int'(bus.sel_req[c*SEL_W +: SEL_W]);
          if (mSwapNow[c]) begin
            mAct[c]     = req;
            mSwapNow[c] = 1'b0;
          end else if (mDown[c]) begin
            if (mGain[c] <= 1) begin
              mGain[c]    = 0;
              mDown[c]    = 1'b0;
              mSwapNow[c] = 1'b1;
            end else begin
              mGain[c] = mGain[c] - 1;
            end
          end else if (req != mAct[c]) begin
            mDown[c] = 1'b1;
          end else if (mGain[c] < FULL) begin
            mGain[c] = mGain[c] + 1;
          end
          e.busy[c] = mDown[c] || mSwapNow[c] || (mGain[c] < FULL);
        end
        expQ.push_back(e);
      end
    end
  end

  // Monitor: the stage presents a fresh output every cycle; score it on the falling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!reset && expQ.size() > 0) begin
        monE = expQ.pop_front();
        for (int c = 0; c < NCH; c++) begin
          checkOutput($sformatf("sb_dac%0d", c), dacLane(c), int'(monE.dac[c*DAC_W +: DAC_W]));
          checkOutput($sformatf("sb_busy%0d", c), int'(bus.busy[c]), int'(monE.busy[c]));
          checkOutput($sformatf("sb_sat%0d", c), int'(bus.sat[c]), int'(monE.sat[c]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt, prev, monoBad, ch1Bad, sawMid, reached, maxStep, step, v, r;
    bus.src_data  = '0;
    bus.src_valid = '0;
    bus.sel_req   = '0;
    bus.shift     = '0;
    bus.sat_clr   = 1'b0;
    resetModel();
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("initDac%0d", c), dacLane(c), MID);
      checkOutput($sformatf("initBusy%0d", c), int'(bus.busy[c]), 0);
      checkOutput($sformatf("initSat%0d", c), int'(bus.sat[c]), 0);
    end

    // Scaling and floor rounding
    setShift(0, 2);
    applyStimulus(0, 1024);
    repeat (3) @(negedge sys_clk);
    checkOutput("scale1024sh2", dacLane(0), 8448);
    setShift(0, 1);
    applyStimulus(0, -3);
    repeat (3) @(negedge sys_clk);
    checkOutput("scaleNeg3sh1", dacLane(0), 8190);

    // Saturation, sticky flag and clear
    setShift(0, 0);
    applyStimulus(0, 32767);
    repeat (3) @(negedge sys_clk);
    checkOutput("satPosCode", dacLane(0), 16383);
    checkOutput("satPosFlag", int'(bus.sat[0]), 1);
    applyStimulus(0, -32768);
    repeat (3) @(negedge sys_clk);
    checkOutput("satNegCode", dacLane(0), 0);
    checkOutput("satNegFlag", int'(bus.sat[0]), 1);
    applyStimulus(0, 100);
    repeat (3) @(negedge sys_clk);
    bus.sat_clr = 1'b1;
    @(negedge sys_clk);
    bus.sat_clr = 1'b0;
    checkOutput("satClr0", int'(bus.sat[0]), 0);
    checkOutput("satClr1", int'(bus.sat[1]), 0);

    // Uninterrupted switch of ch0 from source 0 to source 1
    applyStimulus(0, 1024);
    applyStimulus(1, -1024);
    repeat (3) @(negedge sys_clk);
    setSel(0, 1);
    cnt = 0; prev = dacLane(0); monoBad = 0; ch1Bad = 0; sawMid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (bus.busy[0]) cnt++;
      if (dacLane(0) > prev) monoBad++;
      if (dacLane(0) == MID) sawMid = 1;
      if (dacLane(1) != 9216) ch1Bad++;
      prev = dacLane(0);
    end
    checkOutput("switchBusyCycles", cnt, 33);
    checkOutput("switchNonMonotonic", monoBad, 0);
    checkOutput("switchMidscaleSeen", sawMid, 1);
    checkOutput("switchCh1Disturbed", ch1Bad, 0);
    checkOutput("switchFinal", dacLane(0), 7168);

    setSel(0, 0);
    repeat (40) @(negedge sys_clk);
    checkOutput("switchBack", dacLane(0), 9216);

    // Reversal during fade-in at gain 10
    setSel(0, 1);
    cnt = 0; reached = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (bus.busy[0]) cnt++;
      if (cnt == 28) begin
        setSel(0, 0);
        reached = 1;
        break;
      end
    end
    checkOutput("reversalReached", reached, 1);
    prev = dacLane(0); maxStep = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      step = dacLane(0) - prev;
      if (step < 0) step = -step;
      if (step > maxStep) maxStep = step;
      prev = dacLane(0);
    end
    checkOutput("reversalStepWithin64", int'(maxStep <= 64), 1);
    checkOutput("reversalFinal", dacLane(0), 9216);
    checkOutput("reversalBusy", int'(bus.busy[0]), 0);

    // Concurrent switches, then periodic source 2 samples on ch1
    setSel(0, 3);
    setSel(1, 2);
    repeat (40) @(negedge sys_clk);
    prev = MID;
    for (int k = 0; k < 6; k++) begin
      v = int'($urandom_range(0, 16382)) - 8191;
      bus.src_data[2*IN_W +: IN_W] = IN_W'(v);
      bus.src_valid[2] = 1'b1;
      @(negedge sys_clk);
      bus.src_valid[2] = 1'b0;
      checkOutput("concAfterHold", dacLane(1), prev);
      @(negedge sys_clk);
      checkOutput("concAfterS1", dacLane(1), prev);
      @(negedge sys_clk);
      checkOutput("concAfterS2", dacLane(1), v + MID);
      prev = v + MID;
      repeat (5) @(negedge sys_clk);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < NSRC; s++) begin
        if ($urandom_range(0, 1) == 0) bus.src_data[s*IN_W +: IN_W] = IN_W'($urandom);
        else bus.src_data[s*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 4000)) - 2000);
      end
      bus.src_valid = NSRC'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 29) == 0) setSel(c, int'($urandom_range(0, 3)));
        if ($urandom_range(0, 49) == 0) setShift(c, int'($urandom_range(0, 15)));
      end
      bus.sat_clr = ($urandom_range(0, 15) == 0);
      @(negedge sys_clk);
    end
    bus.sat_clr   = 1'b0;
    bus.src_valid = '0;

    // Asynchronous reset in the middle of a fade
    r = int'(bus.sel_req[SEL_W-1:0]);
    setSel(0, (r + 1) % 4);
    setShift(0, 0);
    bus.src_data  = {NSRC{16'h7fff}};
    bus.src_valid = '1;
    repeat (5) @(negedge sys_clk);
    #3;
    reset = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("asyncResetDac%0d", c), dacLane(c), MID);
      checkOutput($sformatf("asyncResetBusy%0d", c), int'(bus.busy[c]), 0);
      checkOutput($sformatf("asyncResetSat%0d", c), int'(bus.sat[c]), 0);
    end
    bus.src_valid = '0;
    bus.sel_req   = '0;
    bus.shift     = '0;
    resetModel();
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    applyStimulus(0, 2000);
    repeat (3) @(negedge sys_clk);
    checkOutput("postResetCh0Src0", dacLane(0), MID + 2000);
    checkOutput("postResetCh1Src0", dacLane(1), MID + 2000);

    repeat (3) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
